md_ctrl: RTL
============

# md_ctrl

Multiply/divide sequencer for the five-stage MIPS pipeline. It owns the HI/LO registers and counts off the fixed mult/div latencies, accepting one operation per issue from the E stage. It drives a stall request to the hazard logic whenever a D-stage instruction needs the multiply/divide unit while it is busy. It also honours the exception-cancel signal so that a flushed E-stage instruction never modifies HI/LO.

## Interface
- MULT_CYC, 5: busy cycles for MULT/MULTU/MADD/MADDU (≥2)
- DIV_CYC, 10: busy cycles for DIV/DIVU (≥2)

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- md_start  in  1  E stage holds a mult/div/mt instruction this cycle
- md_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
- md_cancel  in  1  E-stage instruction is being flushed (exception/interrupt at M); suppresses md_start
- md_a  in  32  rs operand (E-stage forwarded value)
- md_b  in  32  rt operand (E-stage forwarded value)
- d_md_use  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo/madd*
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  a multi-cycle operation is in flight
- stall_req  out  1  to hazard unit; freeze D, bubble E

## Operation
- accept = md_start & ~md_cancel & ~busy. md_start while busy is ignored; this is a hazard-unit bug, and the bench flags it.
- States: IDLE and RUN. A 4-bit down-counter cnt tracks progress.
- IDLE, accept, op ∈ {MULT, MULTU, DIV, DIVU, MADD*}:
  - latch md_a and md_b
  - latch op
  - cnt ← MULT_CYC or DIV_CYC
  - go to RUN
- IDLE, accept, MTHI/MTLO: hi or lo ← md_a at that edge; stay IDLE; busy stays 0.
- RUN: cnt decrements each edge. On the edge where cnt==1:
  - write HI/LO from the latched operands
  - return to IDLE
- Arithmetic:
  - MULT is signed 32×32→64; MULTU is unsigned. {hi,lo} ← product.
  - DIV/DIVU: lo ← quotient, hi ← remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero: HI/LO are left unchanged. The unit still runs DIV_CYC busy cycles.
- The result is computed from the latched operands only. Later changes on md_a/md_b have no effect.
- stall_req = d_md_use & (busy | accept), combinational.
- MADD/MADDU when MD_CTRL_MADD_EN is undefined: treated as no-op. No accept, no busy, HI/LO untouched.

## Timing
- Reset (async, reset_n=0) sets hi=0, lo=0, busy=0, cnt=0, state IDLE. This takes effect immediately, including mid-operation; the in-flight result is discarded.
- Start at edge E0 (accept=1 in the cycle before E0):
  - busy=1 for exactly N cycles after E0 (N = MULT_CYC or DIV_CYC)
  - HI/LO take the new value at edge E0+N
  - busy=0 in the same cycle that the new HI/LO become visible
- Back-to-back ops: a new accept is possible in the first cycle with busy=0, so the issue spacing is N+1 cycles.
- MTHI/MTLO: the write is visible in the cycle after accept.
- md_cancel with md_start in the same cycle: no state change, and stall_req does not include accept.
- stall_req rises in the accept cycle when d_md_use=1. It falls in the cycle where busy falls.

## Configuration
- MD_CTRL_MADD_EN defined: MADD/MADDU are accepted and take MULT_CYC cycles. {hi,lo} ← {hi,lo} + product (signed/unsigned), with 64-bit wrap-around. HI/LO are sampled at completion, not at accept.
- MD_CTRL_MADD_EN undefined: the accumulate path is not built, and op codes 110/111 are ignored as described above.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU 0x00000007 / 0x00000002 → busy 10 cycles; then lo=3, hi=1. DIV 0xFFFFFFF9 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV by zero with hi=0x11, lo=0x22 → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- md_start=1 and md_cancel=1 with MULT → busy stays 0, HI/LO unchanged, stall_req=0 even with d_md_use=1.
- MULT started, d_md_use=1 throughout → stall_req=1 for 6 cycles (accept cycle + 5). Then MTLO 0xABCD issued; lo=0xABCD next cycle.
- reset_n pulsed low at cycle 3 of a DIV → hi=lo=0, busy=0 at once; next DIVU runs a full 10 cycles. With MD_CTRL_MADD_EN: hi=0, lo=5, MADDU 2×3 → lo=11 after 5 cycles.

Source files
------------

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer for the five-stage MIPS pipeline.
//
// This block owns the HI/LO registers. It accepts one operation per issue from
// the E stage and counts off the fixed mult/div latency. While the unit is
// busy, it raises a stall request for any D-stage instruction that uses it.
//
// Optional feature: define MD_CTRL_MADD_EN to build the MADD/MADDU
// accumulate path. Without it, op codes 110/111 are ignored.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   md_start   in   1   E stage holds a mult/div/mt instruction
//   md_op      in   3   000 MULT 001 MULTU 010 DIV 011 DIVU 100 MTHI 101 MTLO
//                       110 MADD 111 MADDU
//   md_cancel  in   1   E-stage instruction is being flushed
//   md_a       in  32   rs operand
//   md_b       in  32   rt operand
//   d_md_use   in   1   D-stage instruction uses the md unit
//   hi, lo     out 32   HI / LO registers
//   busy       out  1   multi-cycle operation in flight
//   stall_req  out  1   freeze D, bubble E
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation in flight; MT* writes and new starts are accepted
// RUN   | counting down latched op; HI/LO written on the edge cnt==1
module md_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic        md_cancel,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        d_md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic        long_op;
  logic        is_div;
  logic [3:0]  cnt_load;

  logic        res_wr;
  logic [31:0] res_hi, res_lo;
  logic [63:0] prod;
  logic [31:0] dvd_abs, dvs_abs, quo_abs, rem_abs;

  // The idle check goes directly on the state register so that accept does
  // not depend on the busy output logic.
  assign accept = md_start & ~md_cancel & (state_q == IDLE);

`ifdef MD_CTRL_MADD_EN
  assign long_op = (md_op != OP_MTHI) && (md_op != OP_MTLO);
`else
  assign long_op = (md_op[2] == 1'b0);
`endif

  assign is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign cnt_load = is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && long_op) state_d = RUN;
      RUN:  if (cnt_q == 4'd1)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q == RUN);
    stall_req = d_md_use & ((state_q == RUN) | accept);
  end

  // Result path. It only reads the latched operands, so changes on md_a or
  // md_b during RUN are ignored.
  always_comb begin
    res_wr  = 1'b0;
    res_hi  = hi_q;
    res_lo  = lo_q;
    prod    = 64'd0;
    dvd_abs = a_q;
    dvs_abs = b_q;
    quo_abs = 32'd0;
    rem_abs = 32'd0;

    // Sign- or zero-extend to 64 bits. The low 64 bits of the product are
    // then correct for both signed and unsigned operands.
    if (op_q[0] == 1'b0)
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else
      prod = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide works on magnitudes. The quotient is then negated when
    // the operand signs differ, and the remainder follows the dividend.
    // 0x80000000 / -1 wraps naturally to 0x80000000 with remainder 0.
    if (op_q == OP_DIV) begin
      dvd_abs = a_q[31] ? (~a_q + 32'd1) : a_q;
      dvs_abs = b_q[31] ? (~b_q + 32'd1) : b_q;
    end
    if (dvs_abs != 32'd0) begin
      quo_abs = dvd_abs / dvs_abs;
      rem_abs = dvd_abs % dvs_abs;
    end

    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_wr = 1'b1;
        {res_hi, res_lo} = prod;
      end
      OP_DIV: begin
        res_wr = (b_q != 32'd0);
        res_lo = (a_q[31] ^ b_q[31]) ? (~quo_abs + 32'd1) : quo_abs;
        res_hi = a_q[31] ? (~rem_abs + 32'd1) : rem_abs;
      end
      OP_DIVU: begin
        res_wr = (b_q != 32'd0);
        res_lo = quo_abs;
        res_hi = rem_abs;
      end
`ifdef MD_CTRL_MADD_EN
      OP_MADD, OP_MADDU: begin
        // HI/LO are read at completion, so an MT* write cannot slip in
        // between accept and completion and be lost.
        res_wr = 1'b1;
        {res_hi, res_lo} = {hi_q, lo_q} + prod;
      end
`endif
      default: res_wr = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
      op_q  <= OP_MULT;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        if (long_op) begin
          a_q   <= md_a;
          b_q   <= md_b;
          op_q  <= md_op;
          cnt_q <= cnt_load;
        end else if (md_op == OP_MTHI) begin
          hi_q <= md_a;
        end else if (md_op == OP_MTLO) begin
          lo_q <= md_a;
        end
      end
    end else begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1 && res_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
